connect_four_buttons: RTL



---
 rtl/connect_four_buttons.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/connect_four_buttons.sv
// Button front end for the Connect Four core: synchronises, debounces and
// edge-detects three push buttons, adding auto-repeat to the left/right moves.
module connect_four_buttons #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 3750000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    output logic       drop_piece,
    output logic       move_right,
    output logic       move_left,
    output logic [2:0] btn_level
);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, BOTH} state_t;

    logic [2:0] s1_reg;
    logic [2:0] s2_reg;
    logic [2:0] level_reg;
    logic [2:0] level_d_reg;
    logic [2:0] rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg      <= '0;
            s2_reg      <= '0;
            level_d_reg <= '0;
        end else begin
            s1_reg      <= btn_raw;
            s2_reg      <= s1_reg;
            level_d_reg <= level_reg;
        end
    end

    // Per-button debounce: a new level must persist DEBOUNCE_CYCLES samples.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg       <= '0;
                    level_reg[gi] <= 1'b0;
                end else if (s2_reg[gi] == level_reg[gi]) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DEB_LAST) begin
                    level_reg[gi] <= s2_reg[gi];
                    cnt_reg       <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign rise = level_reg & ~level_d_reg;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic             dir_reg, dir_next;      // 1 = left, 0 = right
    logic             left_reg, left_next;
    logic             right_reg, right_next;
    logic             drop_reg;
    logic             held_act;
    logic             held_opp;

    assign held_act = dir_reg ? level_reg[2] : level_reg[1];
    assign held_opp = dir_reg ? level_reg[1] : level_reg[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            dir_reg   <= 1'b0;
            left_reg  <= 1'b0;
            right_reg <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            dir_reg   <= dir_next;
            left_reg  <= left_next;
            right_reg <= right_next;
            drop_reg  <= rise[0];
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        dir_next   = dir_reg;
        left_next  = 1'b0;
        right_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rise[1] && rise[2]) begin
                    state_next = BOTH;
                end else if (rise[1] || rise[2]) begin
                    dir_next   = rise[2];
                    left_next  = rise[2];
                    right_next = rise[1];
                    timer_next = DELAY_LAST;
                    state_next = DELAY;
                end
            end
            DELAY, REPEAT: begin
                // Release wins over a simultaneous opposite press.
                if (!held_act) begin
                    state_next = IDLE;
                end else if (held_opp) begin
                    state_next = BOTH;
                end else if (timer_reg == '0) begin
                    left_next  = dir_reg;
                    right_next = ~dir_reg;
                    timer_next = RATE_LAST;
                    state_next = REPEAT;
                end else begin
                    timer_next = timer_reg - CNT_W'(1);
                end
            end
            BOTH: begin
                if (level_reg[2:1] == 2'b00) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign drop_piece = drop_reg;
    assign move_left  = left_reg;
    assign move_right = right_reg;
    assign btn_level  = level_reg;

endmodule
